// File: rtl/fir_wb_scheduler_if.sv
// Wishbone slave bus bundle for the FIR run scheduler.
// Signal names follow the Caravel user-project wishbone port names.
interface fir_wb_scheduler_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fir_wb_scheduler.sv
// Wishbone-mapped sequencer for one FIR run: start pulse,
// X sample feed into the FIR stream, Y result buffering.
module fir_wb_scheduler #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fir_wb_scheduler_if.slave wb,
  output logic              ss_tvalid,
  output logic              ss_tlast,
  output logic [31:0]       ss_tdata,
  input  logic              ss_tready,
  input  logic              sm_tvalid,
  input  logic              sm_tlast,
  input  logic [31:0]       sm_tdata,
  output logic              sm_tready,
  output logic              fir_start_o,
  output logic              irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] push_cnt;
  logic [15:0] pop_cnt;
  logic [31:0] cycles;
  logic        done;
  logic        start_pend;
  logic        x_drop;
  logic        y_underflow;
  logic        tlast_err;

  logic [32:0]   in_mem [FIFO_DEPTH];
  logic [AW-1:0] in_wp;
  logic [AW-1:0] in_rp;
  logic [CW-1:0] in_cnt;
  logic [31:0]   out_mem [FIFO_DEPTH];
  logic [AW-1:0] out_wp;
  logic [AW-1:0] out_rp;
  logic [CW-1:0] out_cnt;

  logic in_full, in_empty;
  logic out_full, out_empty;
  assign in_full   = in_cnt == FULL_C;
  assign in_empty  = in_cnt == '0;
  assign out_full  = out_cnt == FULL_C;
  assign out_empty = out_cnt == '0;

  logic run, busy, idle;
  assign run  = state == S_RUN;
  assign busy = run;
  assign idle = !run;

  logic       in_win, req, wr;
  logic [7:0] off;
  assign in_win = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign off    = wb.wbs_adr_i[7:0];
  assign wr     = wb.wbs_we_i;
  assign req    = wb.wbs_cyc_i & wb.wbs_stb_i
                & in_win & !wb.wbs_ack_o;

  logic sel_ctrl, sel_len, sel_cyc;
  logic sel_stat, sel_x, sel_y;
  assign sel_ctrl = off == 8'h00;
  assign sel_len  = off == 8'h04;
  assign sel_cyc  = off == 8'h08;
  assign sel_stat = off == 8'h0C;
  assign sel_x    = off == 8'h10;
  assign sel_y    = off == 8'h14;

  logic x_acc, x_ok, x_stall;
  logic y_acc, y_stall, accept;
  logic x_push, y_pop, ss_pop, sm_push;
  logic [15:0] pop_nxt;

  assign x_acc   = req & wr & sel_x;
  assign x_ok    = run && (push_cnt < len);
  assign x_stall = x_acc & x_ok & in_full;
  assign y_acc   = req & !wr & sel_y;
  assign y_stall = y_acc & out_empty & run;
  assign accept  = req & !x_stall & !y_stall;
  assign x_push  = accept & x_acc & x_ok;
  assign y_pop   = accept & y_acc & !out_empty;
  assign ss_pop  = ss_tvalid & ss_tready;
  assign sm_push = sm_tvalid & sm_tready;
  assign pop_nxt = pop_cnt + 16'd1;

  assign ss_tvalid = !in_empty;
  assign ss_tdata  = ss_tvalid ? in_mem[in_rp][31:0] : '0;
  assign ss_tlast  = ss_tvalid & in_mem[in_rp][32];
  assign sm_tready = run & !out_full;

  logic unused_sel;
  assign unused_sel = ^wb.wbs_sel_i;

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = {29'd0, idle, done, busy};
      sel_len:  rdata = {16'd0, len};
      sel_cyc:  rdata = cycles;
      sel_stat: rdata = {21'd0, tlast_err, y_underflow,
                         x_drop, 4'd0, out_empty,
                         out_full, in_empty, in_full};
      sel_y:    rdata = out_empty ? '0 : out_mem[out_rp];
      default:  rdata = '0;
    endcase
  end

  // Storage arrays carry no reset; occupancy counters gate them.
  always_ff @(posedge wb_clk_i) begin
    if (x_push)
      in_mem[in_wp] <= {push_cnt == len - 16'd1,
                        wb.wbs_dat_i};
    if (sm_push)
      out_mem[out_wp] <= sm_tdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_wp   <= '0;
      in_rp   <= '0;
      in_cnt  <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (x_push)  in_wp  <= in_wp + AW'(1);
      if (ss_pop)  in_rp  <= in_rp + AW'(1);
      if (sm_push) out_wp <= out_wp + AW'(1);
      if (y_pop)   out_rp <= out_rp + AW'(1);
      in_cnt  <= in_cnt + CW'(x_push) - CW'(ss_pop);
      out_cnt <= out_cnt + CW'(sm_push) - CW'(y_pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      len          <= '0;
      push_cnt     <= '0;
      pop_cnt      <= '0;
      cycles       <= '0;
      done         <= 1'b0;
      start_pend   <= 1'b0;
      x_drop       <= 1'b0;
      y_underflow  <= 1'b0;
      tlast_err    <= 1'b0;
      fir_start_o  <= 1'b0;
      irq_o        <= 1'b0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= accept;
      wb.wbs_dat_o <= (accept && !wr) ? rdata : '0;
      fir_start_o  <= 1'b0;
      start_pend   <= 1'b0;

      if (accept && wr) begin
        if (sel_ctrl && wb.wbs_dat_i[0])
          start_pend <= !run && (len != '0);
        if (sel_len && !run)
          len <= wb.wbs_dat_i[15:0];
        if (sel_stat) begin
          x_drop      <= x_drop & ~wb.wbs_dat_i[8];
          y_underflow <= y_underflow & ~wb.wbs_dat_i[9];
          tlast_err   <= tlast_err & ~wb.wbs_dat_i[10];
        end
        if (sel_x && !x_ok)
          x_drop <= 1'b1;
      end

      if (accept && !wr && sel_ctrl)
        irq_o <= 1'b0;
      if (accept && !wr && sel_y && out_empty)
        y_underflow <= 1'b1;

      if (run && cycles != '1)
        cycles <= cycles + 32'd1;
      if (x_push)
        push_cnt <= push_cnt + 16'd1;

      // tlast must mark exactly the LEN-th output.
      if (sm_push) begin
        pop_cnt <= pop_nxt;
        if (sm_tlast != (pop_nxt == len))
          tlast_err <= 1'b1;
        if (pop_nxt == len) begin
          state <= S_DONE;
          done  <= 1'b1;
          irq_o <= 1'b1;
        end
      end

      if (start_pend) begin
        state       <= S_RUN;
        fir_start_o <= 1'b1;
        done        <= 1'b0;
        irq_o       <= 1'b0;
        push_cnt    <= '0;
        pop_cnt     <= '0;
        cycles      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fir_wb_scheduler.sv
// Randomized self-checking bench for fir_wb_scheduler with a
// queue-based FIR stream model.
module tb_fir_wb_scheduler;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_LEN  = 32'h04;
  localparam logic [31:0] A_CYC  = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_X    = 32'h10;
  localparam logic [31:0] A_Y    = 32'h14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ss_tvalid, ss_tlast;
  logic [31:0] ss_tdata;
  logic ss_tready = 1'b0;
  logic sm_tvalid = 1'b0;
  logic sm_tlast = 1'b0;
  logic [31:0] sm_tdata = '0;
  logic sm_tready, fir_start, irq;
  int tests = 0;
  int fails = 0;

  fir_wb_scheduler_if bus();

  fir_wb_scheduler #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb(bus),
    .ss_tvalid(ss_tvalid),
    .ss_tlast(ss_tlast),
    .ss_tdata(ss_tdata),
    .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid),
    .sm_tlast(sm_tlast),
    .sm_tdata(sm_tdata),
    .sm_tready(sm_tready),
    .fir_start_o(fir_start),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  // FIR model: y = 3x+1, in order, tlast on output tlast_at.
  logic [31:0] fir_q[$];
  logic [31:0] x_seen[$];
  bit          last_seen[$];
  bit fir_hold = 1'b0;
  int tlast_at = 0;
  int out_idx = 0;
  int sm_hs_cnt = 0;
  int starts = 0;
  int run_cycles = 0;
  bit counting = 1'b0;

  always begin : fir_model
    logic cap_ss, cap_sm, cap_l;
    logic [31:0] cap_d;
    @(negedge clk);
    cap_ss = ss_tvalid && ss_tready && !rst;
    cap_sm = sm_tvalid && sm_tready && !rst;
    cap_d  = ss_tdata;
    cap_l  = ss_tlast;
    if (fir_start) begin
      starts++;
      counting = 1'b1;
      run_cycles = 1;
    end else if (counting) begin
      if (irq) counting = 1'b0;
      else run_cycles++;
    end
    @(posedge clk);
    #1;
    if (cap_ss) begin
      x_seen.push_back(cap_d);
      last_seen.push_back(cap_l);
      fir_q.push_back(cap_d * 32'd3 + 32'd1);
    end
    if (cap_sm && fir_q.size() > 0) begin
      void'(fir_q.pop_front());
      out_idx++;
      sm_hs_cnt++;
    end
    sm_tvalid = !fir_hold && fir_q.size() > 0;
    sm_tdata  = sm_tvalid ? fir_q[0] : '0;
    sm_tlast  = sm_tvalid && (out_idx + 1 == tlast_at);
  end

  task automatic wb_xfer(input bit we, input logic [31:0] off,
                         input logic [31:0] wd, input bit exp_ack,
                         output logic [31:0] rd, output bit ok);
    int n;
    int budget;
    budget = exp_ack ? 300 : 10;
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + off;
    bus.wbs_dat_i = wd;
    ok = 1'b0;
    rd = '0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.wbs_ack_o) begin
        ok = 1'b1;
        rd = bus.wbs_dat_o;
      end
    end
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (exp_ack) begin
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL wb_ack off=%h: ack=0 want 1", off);
      end
    end
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = irq;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ss_tready = 1'b0;
    @(negedge clk);
    fir_q.delete();
    x_seen.delete();
    last_seen.delete();
    out_idx = 0;
    sm_hs_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_run(input int len, input int tl);
    logic [31:0] rd;
    bit ok;
    @(negedge clk);
    x_seen.delete();
    last_seen.delete();
    out_idx = 0;
    sm_hs_cnt = 0;
    tlast_at = tl;
    fir_hold = 1'b0;
    wb_xfer(1, A_LEN, len, 1, rd, ok);
    wb_xfer(1, A_CTRL, 32'd1, 1, rd, ok);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bit ok;
    do_reset();
    @(negedge clk);
    tests++;
    if ({irq, fir_start, ss_tvalid, sm_tready, bus.wbs_ack_o} !== 5'b0
        || bus.wbs_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %b/%h want 0/0",
        {irq, fir_start, ss_tvalid, sm_tready, bus.wbs_ack_o},
        bus.wbs_dat_o);
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h4) begin
      fails++; $display("FAIL ctrl_reset: got %h want 4", rd);
    end
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'hA) begin
      fails++; $display("FAIL stat_reset: got %h want a", rd);
    end
    wb_xfer(0, A_LEN, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL len_reset: got %h want 0", rd);
    end
    wb_xfer(1, A_CTRL, 32'd1, 1, rd, ok);
    repeat (4) @(negedge clk);
    tests++;
    if (starts !== 0) begin
      fails++; $display("FAIL start_len0: got %0d pulses want 0", starts);
    end
    wb_xfer(1, A_X, $urandom, 1, rd, ok);
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h10A) begin
      fails++; $display("FAIL x_drop_idle: got %h want 10a", rd);
    end
    wb_xfer(1, 32'h100, 32'd1, 0, rd, ok);
    tests++;
    if (ok !== 1'b0) begin
      fails++; $display("FAIL out_of_window: ack=%b want 0", ok);
    end
    wb_xfer(0, 32'h20, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL unmapped_rd: got %h want 0", rd);
    end
    wb_xfer(1, A_STAT, 32'h700, 1, rd, ok);
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'hA) begin
      fails++; $display("FAIL stat_clear: got %h want a", rd);
    end
  endtask

  task automatic test_normal_run();
    logic [31:0] rd, x;
    logic [31:0] xs[$];
    logic [7:0] lm;
    bit ok;
    int s0;
    s0 = starts;
    start_run(8, 8);
    ss_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      xs.push_back(x);
      wb_xfer(1, A_X, x, 1, rd, ok);
    end
    for (int i = 0; i < 8; i++) begin
      wb_xfer(0, A_Y, 0, 1, rd, ok);
      tests++;
      if (rd !== xs[i] * 32'd3 + 32'd1) begin
        fails++;
        $display("FAIL run_y[%0d]: got %h want %h",
          i, rd, xs[i] * 32'd3 + 32'd1);
      end
    end
    wait_irq(ok);
    tests++;
    if (!ok || starts !== s0 + 1) begin
      fails++;
      $display("FAIL run_done: irq=%b starts=%0d want 1/%0d",
        ok, starts, s0 + 1);
    end
    lm = '0;
    for (int i = 0; i < last_seen.size() && i < 8; i++)
      lm[i] = last_seen[i];
    tests++;
    if (x_seen.size() != 8 || lm !== 8'h80) begin
      fails++;
      $display("FAIL ss_tlast: n=%0d mask=%h want 8/80",
        x_seen.size(), lm);
    end
    for (int i = 0; i < 8 && i < x_seen.size(); i++) begin
      tests++;
      if (x_seen[i] !== xs[i]) begin
        fails++;
        $display("FAIL ss_data[%0d]: got %h want %h",
          i, x_seen[i], xs[i]);
      end
    end
    wb_xfer(0, A_CYC, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'(run_cycles)) begin
      fails++;
      $display("FAIL cycles: got %0d want %0d", rd, run_cycles);
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h6) begin
      fails++; $display("FAIL ctrl_done: got %h want 6", rd);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_clear: got %b want 0", irq);
    end
    wb_xfer(0, A_Y, 0, 1, rd, ok);
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h20A) begin
      fails++; $display("FAIL y_underflow: got %h want 20a", rd);
    end
    wb_xfer(1, A_STAT, 32'h700, 1, rd, ok);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, rd5, yrd;
    logic [31:0] xs[$];
    bit ok, ok5, okw, x5_done, y_done;
    start_run(5, 5);
    ss_tready = 1'b0;
    @(negedge clk);
    fir_hold = 1'b1;
    for (int i = 0; i < 5; i++) xs.push_back($urandom);
    for (int i = 0; i < 4; i++) wb_xfer(1, A_X, xs[i], 1, rd, ok);
    x5_done = 1'b0;
    fork
      begin
        wb_xfer(1, A_X, xs[4], 1, rd5, ok5);
        x5_done = 1'b1;
      end
      begin
        repeat (10) @(negedge clk);
        tests++;
        if (x5_done !== 1'b0) begin
          fails++; $display("FAIL x5_stall: acked=%b want 0", x5_done);
        end
        @(posedge clk);
        #1;
        ss_tready = 1'b1;
      end
    join
    y_done = 1'b0;
    fork
      begin
        wb_xfer(0, A_Y, 0, 1, yrd, ok);
        y_done = 1'b1;
      end
      begin
        repeat (8) @(negedge clk);
        tests++;
        if (y_done !== 1'b0) begin
          fails++; $display("FAIL y_stall: acked=%b want 0", y_done);
        end
        fir_hold = 1'b0;
      end
    join
    tests++;
    if (yrd !== xs[0] * 32'd3 + 32'd1) begin
      fails++;
      $display("FAIL bp_y[0]: got %h want %h",
        yrd, xs[0] * 32'd3 + 32'd1);
    end
    for (int i = 1; i < 5; i++) begin
      wb_xfer(0, A_Y, 0, 1, rd, ok);
      tests++;
      if (rd !== xs[i] * 32'd3 + 32'd1) begin
        fails++;
        $display("FAIL bp_y[%0d]: got %h want %h",
          i, rd, xs[i] * 32'd3 + 32'd1);
      end
    end
    wait_irq(okw);
    tests++;
    if (!okw) begin
      fails++; $display("FAIL bp_done: irq=0 want 1");
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
  endtask

  task automatic test_out_full();
    logic [31:0] rd;
    logic [31:0] xs[$];
    bit ok;
    start_run(6, 6);
    ss_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xs.push_back($urandom);
      wb_xfer(1, A_X, xs[i], 1, rd, ok);
    end
    repeat (30) @(negedge clk);
    tests++;
    if (sm_hs_cnt !== 4 || sm_tready !== 1'b0) begin
      fails++;
      $display("FAIL out_full: hs=%0d ready=%b want 4/0",
        sm_hs_cnt, sm_tready);
    end
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h6) begin
      fails++; $display("FAIL stat_full: got %h want 6", rd);
    end
    for (int i = 0; i < 6; i++) begin
      wb_xfer(0, A_Y, 0, 1, rd, ok);
      tests++;
      if (rd !== xs[i] * 32'd3 + 32'd1) begin
        fails++;
        $display("FAIL full_y[%0d]: got %h want %h",
          i, rd, xs[i] * 32'd3 + 32'd1);
      end
    end
    wait_irq(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL full_done: irq=0 want 1");
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [31:0] xs[$];
    bit ok;
    start_run(8, 3);
    ss_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      xs.push_back($urandom);
      wb_xfer(1, A_X, xs[i], 1, rd, ok);
    end
    for (int i = 0; i < 8; i++) begin
      wb_xfer(0, A_Y, 0, 1, rd, ok);
      tests++;
      if (rd !== xs[i] * 32'd3 + 32'd1) begin
        fails++;
        $display("FAIL err_y[%0d]: got %h want %h",
          i, rd, xs[i] * 32'd3 + 32'd1);
      end
    end
    wait_irq(ok);
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h50A) begin
      fails++; $display("FAIL err_sticky: got %h want 50a", rd);
    end
    wb_xfer(1, A_STAT, 32'h700, 1, rd, ok);
    wb_xfer(0, A_STAT, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'hA) begin
      fails++; $display("FAIL err_clear: got %h want a", rd);
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
  endtask

  task automatic test_midrun();
    logic [31:0] rd;
    logic [31:0] xs[$];
    bit ok;
    int s0;
    start_run(8, 8);
    ss_tready = 1'b0;
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h1) begin
      fails++; $display("FAIL ctrl_busy: got %h want 1", rd);
    end
    s0 = starts;
    wb_xfer(1, A_CTRL, 32'd1, 1, rd, ok);
    wb_xfer(1, A_LEN, 32'd3, 1, rd, ok);
    repeat (3) @(negedge clk);
    wb_xfer(0, A_LEN, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'd8 || starts !== s0) begin
      fails++;
      $display("FAIL run_ignore: len=%0d starts=%0d want 8/%0d",
        rd, starts, s0);
    end
    wb_xfer(1, A_X, $urandom, 1, rd, ok);
    wb_xfer(1, A_X, $urandom, 1, rd, ok);
    @(negedge clk);
    tests++;
    if (ss_tvalid !== 1'b1) begin
      fails++; $display("FAIL ss_queued: got %b want 1", ss_tvalid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    fir_q.delete();
    x_seen.delete();
    last_seen.delete();
    @(negedge clk);
    tests++;
    if (ss_tvalid !== 1'b0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL rst_flush: tvalid=%b irq=%b want 0/0",
        ss_tvalid, irq);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h4) begin
      fails++; $display("FAIL ctrl_after_rst: got %h want 4", rd);
    end
    start_run(2, 2);
    ss_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      xs.push_back($urandom);
      wb_xfer(1, A_X, xs[i], 1, rd, ok);
    end
    for (int i = 0; i < 2; i++) begin
      wb_xfer(0, A_Y, 0, 1, rd, ok);
      tests++;
      if (rd !== xs[i] * 32'd3 + 32'd1) begin
        fails++;
        $display("FAIL fresh_y[%0d]: got %h want %h",
          i, rd, xs[i] * 32'd3 + 32'd1);
      end
    end
    wait_irq(ok);
    wb_xfer(0, A_CYC, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'(run_cycles)) begin
      fails++;
      $display("FAIL fresh_cycles: got %0d want %0d", rd, run_cycles);
    end
    wb_xfer(0, A_CTRL, 0, 1, rd, ok);
    tests++;
    if (rd !== 32'h6) begin
      fails++; $display("FAIL fresh_done: got %h want 6", rd);
    end
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    test_reset();
    test_normal_run();
    test_backpressure();
    test_out_full();
    test_errors();
    test_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
